// File: rtl/mux_2_1_arbiter_pkg.sv
// rtl/mux_2_1_arbiter_pkg.sv - shared state encodings and helpers for the two-port arbiter
package mux_2_1_arbiter_pkg;

  localparam int DEFAULT_BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  function automatic state_t busy_state(input logic owner);
    return owner ? ST_BUSY1 : ST_BUSY0;
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// rtl/mux_2_1.sv - two-input data mux, sel=1 picks in1
module mux_2_1 #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 sel,
  input  logic [BUS_WIDTH-1:0] in0,
  input  logic [BUS_WIDTH-1:0] in1,
  output logic [BUS_WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_2_1_arbiter.sv
// rtl/mux_2_1_arbiter.sv - round-robin, burst-locked arbiter for two valid/ready sources
module mux_2_1_arbiter
  import mux_2_1_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0_valid,
  input  logic [BUS_WIDTH-1:0] in0_data,
  input  logic                 in0_last,
  output logic                 in0_ready,
  input  logic                 in1_valid,
  input  logic [BUS_WIDTH-1:0] in1_data,
  input  logic                 in1_last,
  output logic                 in1_ready,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 grant,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic                 prio;
  logic                 grant_nxt;
  logic                 can_load;
  logic                 load;
  logic                 cur_last;
  logic [BUS_WIDTH-1:0] mux_out;

  mux_2_1 #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
    .sel (grant),
    .in0 (in0_data),
    .in1 (in1_data),
    .out (mux_out)
  );

  // The output slot is free when empty or being drained this cycle.
  assign can_load = ~out_valid | out_ready;
  assign cur_last = grant ? in1_last : in0_last;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in0_valid & in1_valid) begin
          state_nxt = busy_state(prio);
          grant_nxt = prio;
        end else if (in0_valid) begin
          state_nxt = ST_BUSY0;
          grant_nxt = 1'b0;
        end else if (in1_valid) begin
          state_nxt = ST_BUSY1;
          grant_nxt = 1'b1;
        end
      end
      ST_BUSY0: begin
        in0_ready = can_load;
        load      = in0_valid & can_load;
        if (load & in0_last) state_nxt = ST_IDLE;
      end
      ST_BUSY1: begin
        in1_ready = can_load;
        load      = in1_valid & can_load;
        if (load & in1_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      // Priority flips to the other side only once a whole burst is done.
      if (load & cur_last) prio <= ~grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_last  <= cur_last;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// tb/tb_mux_2_1_arbiter.sv - directed self-checking bench for mux_2_1_arbiter
module tb_mux_2_1_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in0_valid = 1'b0, in0_last = 1'b0, in0_ready;
  logic [W-1:0] in0_data = '0;
  logic         in1_valid = 1'b0, in1_last = 1'b0, in1_ready;
  logic [W-1:0] in1_data = '0;
  logic         out_valid, out_last, grant, busy;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  mux_2_1_arbiter #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: step past the edge, drive inputs, then check registered and ready outputs.
  task automatic vec(input string tag,
                     input logic v0, input logic [W-1:0] d0, input logic l0,
                     input logic v1, input logic [W-1:0] d1, input logic l1,
                     input logic ordy,
                     input logic er0, input logic er1, input logic eov,
                     input logic [W-1:0] eod, input logic eol,
                     input logic egr, input logic ebusy);
    @(posedge clk);
    #1;
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
    #1;
    check({tag, ".in0_ready"}, W'(in0_ready), W'(er0));
    check({tag, ".in1_ready"}, W'(in1_ready), W'(er1));
    check({tag, ".out_valid"}, W'(out_valid), W'(eov));
    check({tag, ".out_data"},  out_data,      eod);
    check({tag, ".out_last"},  W'(out_last),  W'(eol));
    check({tag, ".grant"},     W'(grant),     W'(egr));
    check({tag, ".busy"},      W'(busy),      W'(ebusy));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    check({tag, ".out_valid"}, W'(out_valid), '0);
    check({tag, ".out_data"},  out_data,      '0);
    check({tag, ".out_last"},  W'(out_last),  '0);
    check({tag, ".grant"},     W'(grant),     '0);
    check({tag, ".busy"},      W'(busy),      '0);
    check({tag, ".in0_ready"}, W'(in0_ready), '0);
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset("rst0");
    vec("idle0", 0,0,0, 0,0,0, 1,  0,0, 0,32'h0,0, 0,0);
    vec("idle1", 0,0,0, 0,0,0, 1,  0,0, 0,32'h0,0, 0,0);

    // Single 3-beat burst from in0.
    vec("s0", 1,32'hA1,0, 0,0,0, 1,  0,0, 0,32'h00,0, 0,0);
    vec("s1", 1,32'hA1,0, 0,0,0, 1,  1,0, 0,32'h00,0, 0,1);
    vec("s2", 1,32'hA2,0, 0,0,0, 1,  1,0, 1,32'hA1,0, 0,1);
    vec("s3", 1,32'hA3,1, 0,0,0, 1,  1,0, 1,32'hA2,0, 0,1);
    vec("s4", 0,32'h00,0, 0,0,0, 1,  0,0, 1,32'hA3,1, 0,0);
    vec("s5", 0,32'h00,0, 0,0,0, 1,  0,0, 0,32'hA3,1, 0,0);

    // Contention from reset: grants alternate per burst with one bubble between.
    do_reset("rst1");
    vec("c0", 1,32'h10,0, 1,32'h20,0, 1,  0,0, 0,32'h00,0, 0,0);
    vec("c1", 1,32'h10,0, 1,32'h20,0, 1,  1,0, 0,32'h00,0, 0,1);
    vec("c2", 1,32'h11,1, 1,32'h20,0, 1,  1,0, 1,32'h10,0, 0,1);
    vec("c3", 1,32'h10,0, 1,32'h20,0, 1,  0,0, 1,32'h11,1, 0,0);
    vec("c4", 1,32'h10,0, 1,32'h20,0, 1,  0,1, 0,32'h11,1, 1,1);
    vec("c5", 1,32'h10,0, 1,32'h21,1, 1,  0,1, 1,32'h20,0, 1,1);
    vec("c6", 1,32'h10,0, 1,32'h20,0, 1,  0,0, 1,32'h21,1, 1,0);
    vec("c7", 1,32'h10,0, 1,32'h20,0, 1,  1,0, 0,32'h21,1, 0,1);
    vec("c8", 1,32'h11,1, 1,32'h20,0, 1,  1,0, 1,32'h10,0, 0,1);
    vec("c9", 0,32'h00,0, 0,32'h00,0, 1,  0,0, 1,32'h11,1, 0,0);
    vec("c10",0,32'h00,0, 0,32'h00,0, 1,  0,0, 0,32'h11,1, 0,0);

    // Backpressure: out_ready low for 4 cycles while 0x55 is held.
    vec("b0", 1,32'h55,0, 0,0,0, 1,  0,0, 0,32'h11,1, 0,0);
    vec("b1", 1,32'h55,0, 0,0,0, 1,  1,0, 0,32'h11,1, 0,1);
    vec("b2", 1,32'h56,1, 0,0,0, 0,  0,0, 1,32'h55,0, 0,1);
    vec("b3", 1,32'h56,1, 0,0,0, 0,  0,0, 1,32'h55,0, 0,1);
    vec("b4", 1,32'h56,1, 0,0,0, 0,  0,0, 1,32'h55,0, 0,1);
    vec("b5", 1,32'h56,1, 0,0,0, 0,  0,0, 1,32'h55,0, 0,1);
    vec("b6", 1,32'h56,1, 0,0,0, 1,  1,0, 1,32'h55,0, 0,1);
    vec("b7", 0,32'h00,0, 0,0,0, 1,  0,0, 1,32'h56,1, 0,0);
    vec("b8", 0,32'h00,0, 0,0,0, 1,  0,0, 0,32'h56,1, 0,0);

    // Burst lock: in1 pauses mid-burst while in0 waits.
    vec("l0", 0,32'h00,0, 1,32'h30,0, 1,  0,0, 0,32'h56,1, 0,0);
    vec("l1", 0,32'h00,0, 1,32'h30,0, 1,  0,1, 0,32'h56,1, 1,1);
    vec("l2", 1,32'h40,1, 0,32'h00,0, 1,  0,1, 1,32'h30,0, 1,1);
    vec("l3", 1,32'h40,1, 0,32'h00,0, 1,  0,1, 0,32'h30,0, 1,1);
    vec("l4", 1,32'h40,1, 0,32'h00,0, 1,  0,1, 0,32'h30,0, 1,1);
    vec("l5", 1,32'h40,1, 1,32'h31,0, 1,  0,1, 0,32'h30,0, 1,1);
    vec("l6", 1,32'h40,1, 1,32'h32,1, 1,  0,1, 1,32'h31,0, 1,1);
    vec("l7", 1,32'h40,1, 0,32'h00,0, 1,  0,0, 1,32'h32,1, 1,0);
    vec("l8", 1,32'h40,1, 0,32'h00,0, 1,  1,0, 0,32'h32,1, 0,1);
    vec("l9", 0,32'h00,0, 0,32'h00,0, 1,  0,0, 1,32'h40,1, 0,0);
    vec("l10",0,32'h00,0, 0,32'h00,0, 1,  0,0, 0,32'h40,1, 0,0);

    // Reset during beat 2 of a 4-beat in0 burst, then in1 first and in0 restarts.
    vec("r0", 1,32'h61,0, 0,0,0, 1,  0,0, 0,32'h40,1, 0,0);
    vec("r1", 1,32'h61,0, 0,0,0, 1,  1,0, 0,32'h40,1, 0,1);
    vec("r2", 1,32'h62,0, 0,0,0, 1,  1,0, 1,32'h61,0, 0,1);
    do_reset("rst2");
    vec("r3", 0,32'h00,0, 1,32'h70,1, 1,  0,0, 0,32'h00,0, 0,0);
    vec("r4", 1,32'h61,0, 1,32'h70,1, 1,  0,1, 0,32'h00,0, 1,1);
    vec("r5", 1,32'h61,0, 0,32'h00,0, 1,  0,0, 1,32'h70,1, 1,0);
    vec("r6", 1,32'h61,0, 0,32'h00,0, 1,  1,0, 0,32'h70,1, 0,1);
    vec("r7", 1,32'h62,0, 0,32'h00,0, 1,  1,0, 1,32'h61,0, 0,1);
    vec("r8", 1,32'h63,0, 0,32'h00,0, 1,  1,0, 1,32'h62,0, 0,1);
    vec("r9", 1,32'h64,1, 0,32'h00,0, 1,  1,0, 1,32'h63,0, 0,1);
    vec("r10",0,32'h00,0, 0,32'h00,0, 1,  0,0, 1,32'h64,1, 0,0);
    vec("r11",0,32'h00,0, 0,32'h00,0, 1,  0,0, 0,32'h64,1, 0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_2_1_arbiter.md
Name: mux_2_1_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares one BUS_WIDTH output channel between two valid/ready requesters.
- Data selection uses one mux_2_1 instance, with its sel driven by the current grant.
- The selected beat lands in a single output register stage.
- Sits in front of any shared downstream resource (bus, FIFO, memory port) that two sources must reach.

Parameters:
- BUS_WIDTH, 32, width of the data path on both inputs and the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  BUS_WIDTH  requester 0 data.
- in0_last  input  1  final beat of requester 0's burst.
- in0_ready  output  1  beat from requester 0 is accepted this cycle.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  BUS_WIDTH  requester 1 data.
- in1_last  input  1  final beat of requester 1's burst.
- in1_ready  output  1  beat from requester 1 is accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  BUS_WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_ready  input  1  downstream accepts the beat.
- grant  output  1  current owner (0 or 1); drives the mux sel.
- busy  output  1  a burst is in progress (state is not IDLE).

Behaviour:
- Reset (async, active-high): state=IDLE, prio=0, grant=0, out_valid=0, out_data=0, out_last=0. Reset mid-burst aborts the burst; the held beat is discarded.
- FSM states: IDLE, BUSY0, BUSY1.
- IDLE: in0_ready=in1_ready=0.
  - Only one input valid: go to BUSY of that input.
  - Both valid: go to BUSY of the input named by prio.
  - None valid: stay in IDLE.
  - grant is registered with the state transition.
- BUSYn:
  - load = inn_valid & (~out_valid | out_ready).
  - inn_ready = (~out_valid | out_ready). This is independent of inn_valid. The other input's ready is 0.
  - On load: out_data <= mux output, out_last <= inn_last, out_valid <= 1.
  - If load & inn_last: next state IDLE, prio <= ~n.
  - Burst lock: when inn_valid drops mid-burst, the grant is held; no other requester is served until a last beat is accepted.
- Output register:
  - out_ready & out_valid & ~load: out_valid <= 0.
  - ~out_ready & out_valid: out_data and out_last hold stable.
  - out_data holds its last value when out_valid=0.
- Latency and throughput:
  - Request seen in IDLE at cycle 0 -> BUSY at cycle 1 -> first beat accepted at cycle 1 -> out_valid at cycle 2.
  - Within a burst: 1 beat/cycle with out_ready=1.
  - Between bursts: exactly one IDLE bubble cycle.
- Single-beat burst (last on the first beat): legal; returns to IDLE after one beat.
- Fairness: with both inputs continuously requesting, grants alternate 0,1,0,1,... at burst granularity.
- No combinational path from inn_valid to out_valid. inn_ready depends combinationally on out_ready.
- busy = (state != IDLE).

Decomposition:
- Shared package/include: state encodings ST_IDLE=2'd0, ST_BUSY0=2'd1, ST_BUSY1=2'd2.
- Sub-module: one mux_2_1 #(BUS_WIDTH) instance with sel=grant, in0=in0_data, in1=in1_data. Its output feeds the output register.
- FSM, prio and output register live in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid=0, out_data=0, grant=0, busy=0 immediately; deassert and drive no valid inputs -> stays IDLE, both readies 0.
- Single requester: in0 sends a 3-beat burst 0xA1, 0xA2, 0xA3 (last on 0xA3) with out_ready=1 -> out beats on cycles 2, 3, 4 in order; out_last only on 0xA3; busy low at cycle 4.
- Contention, fairness: both valid from reset with 2-beat bursts (in0: 0x10, 0x11; in1: 0x20, 0x21) -> output order 0x10, 0x11, bubble, 0x20, 0x21, bubble, 0x10, ...; grant toggles per burst.
- Backpressure: hold out_ready=0 for 4 cycles while out_valid=1 with 0x55 -> out_data stays 0x55, inn_ready=0; release -> next beat on the following cycle, no loss or duplication.
- Burst lock with gap: in1 holds the grant, drops in1_valid for 3 cycles mid-burst while in0_valid=1 -> in0_ready stays 0, grant stays 1, in1 burst completes, then in0 is granted.
- Reset mid-burst: assert rst during beat 2 of a 4-beat in0 burst -> IDLE, out_valid=0; after release, in1 request is granted first (prio=0 → only in1 valid) and in0 restarts cleanly.
